csr_irq_bank: RTL
=================

Name: csr_irq_bank

Overview:
- Parametrised control/status register file with an integrated two-level nesting interrupt controller; next generation of the single-cycle core's CSR block.
- Holds NUM_CSR general CSRs read/written by the core's CSR instructions and exposes them flat to the peripherals (SPI, I2C, UART, timer, watchdog).
- Captures NUM_SRC peripheral interrupt lines synchronously into flag bits.
- Drives a request/acknowledge/iret handshake with the core, supporting one level of high-over-low nesting.

Parameters:
- DATA_W, 32, CSR width.
- ADDR_W, 4, CSR address width.
- NUM_CSR, 16, implemented CSRs; must be ≤ 2^ADDR_W.
- NUM_SRC, 8, interrupt sources; must be ≤ DATA_W.
- IEN_IDX, 5, address of the interrupt-enable register.
- IFLG_IDX, 6, address of the interrupt-flag register.
- IPRI_IDX, 7, address of the priority register; bit=1 means high level.
- ISTAT_IDX, 8, address of the status register.

Ports:
- clk  in  1  Clock, rising edge.
- rst  in  1  Reset: asynchronous, active-high.
- csr_we  in  1  Write enable.
- csr_waddr  in  ADDR_W  Write address.
- csr_wdata  in  DATA_W  Write data.
- csr_raddr  in  ADDR_W  Read address.
- csr_rdata  out  DATA_W  Read data, combinational.
- csr_flat_o  out  NUM_CSR*DATA_W  All CSRs; register i at bits [i*DATA_W +: DATA_W].
- src_i  in  NUM_SRC  Interrupt lines, synchronous to clk, level.
- irq_o  out  1  Interrupt request to core.
- irq_level_o  out  1  Level of the offered request: 1 = high.
- irq_vec_o  out  clog2(NUM_SRC) (min 1)  Index of the offered source.
- irq_ack_i  in  1  Core takes the request; valid only while irq_o=1.
- iret_i  in  1  Core returns from an interrupt handler.

Behaviour:
- Reset: all CSRs = 0, src_prev = 0, FSM = IDLE, hence irq_o=0, irq_level_o=0, irq_vec_o=0. Reset asserted mid-handler discards nesting state immediately.
- Read: csr_rdata = CSR[csr_raddr]; 0 if csr_raddr ≥ NUM_CSR.
- Write: takes effect on the clk edge. Writes to addresses ≥ NUM_CSR are ignored.
- Write to IFLG is write-1-to-clear.
- Write to ISTAT affects bit0 (GIE) only; bits[3:1] are read-only.
- Writes to IEN/IPRI only affect bits [NUM_SRC-1:0]; upper bits read 0.
- Capture: src_prev <= src_i every cycle. IFLG[k] sets on the edge where src_i[k]=1 and src_prev[k]=0. Flag is visible from the next cycle.
- Same-cycle set and W1C clear of one bit: set wins. Flags never auto-clear on ack; software clears them.
- pend_hi = |(IFLG & IEN & IPRI); pend_lo = |(IFLG & IEN & ~IPRI), both over NUM_SRC bits.
- FSM states: IDLE, LOW_ACT, HIGH_ACT, NEST (high running over low).
- ISTAT bits [3:1] = {NEST, HIGH_ACT|NEST, LOW_ACT|NEST}.
- irq_o (combinational) = GIE & ~iret_i & ((IDLE & (pend_hi|pend_lo)) | (LOW_ACT & pend_hi)).
- irq_level_o = 1 when pend_hi, else 0. High always beats low.
- irq_vec_o = lowest-index set bit of the chosen class mask; 0 when irq_o=0.
- Ack transitions, when irq_o=1: IDLE -> HIGH_ACT if level high, else LOW_ACT; LOW_ACT -> NEST.
- Iret transitions: NEST -> LOW_ACT; HIGH_ACT -> IDLE; LOW_ACT -> IDLE; IDLE ignored.
- iret_i and irq_ack_i in the same cycle: iret applies and ack is ignored, because irq_o is forced 0.
- irq_ack_i while irq_o=0: ignored.
- HIGH_ACT and NEST never request. LOW_ACT does not request for a low source.
- A GIE clear masks irq_o next cycle. It does not change FSM state.
- A flag left set after iret re-requests in the following cycle (documented, not an error).

Test Plan:
- Reset check: rst pulse mid-NEST -> irq_o=0 and all CSRs read 0 asynchronously; state after release is IDLE, ISTAT=0.
- Single low interrupt:
  - Setup: IEN=0x08, IPRI=0, GIE=1.
  - src_i[3] rises -> IFLG=0x08 next cycle; irq_o=1, irq_level_o=0, irq_vec_o=3.
  - Ack -> ISTAT=0x3, irq_o=0.
  - W1C 0x08, then iret -> ISTAT=0x1.
- Nesting:
  - Setup: IEN=0x0A, IPRI=0x02. Low src 3 is taken first.
  - src 1 rises -> irq_o=1, level=1, vec=1. Ack -> ISTAT=0xF.
  - iret -> LOW_ACT (ISTAT=0x3). iret -> IDLE (ISTAT=0x1).
- Arbitration: src 5 (low) and src 2 (high) rise together in IDLE -> vec=2, level=1. After the high handler irets with flag 2 cleared -> vec=5, level=0.
- Collisions:
  - W1C of IFLG bit 4 in the same cycle as a src_i[4] rising edge -> bit stays 1.
  - iret_i and irq_ack_i in the same cycle -> only iret takes effect.
- Address range: NUM_CSR=12, write 0xDEAD to address 13 -> ignored; read of address 13 returns 0. csr_flat_o[0 +: DATA_W] tracks writes to address 0 next cycle.

Source files
------------

// File: rtl/csr_irq_bank.sv
// CSR file with write-1-to-clear interrupt flags and a two-level (high over low)
// nesting interrupt controller driving a request/ack/iret handshake with the core.
module csr_irq_bank #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NUM_CSR   = 16,
  parameter int unsigned NUM_SRC   = 8,
  parameter int unsigned IEN_IDX   = 5,
  parameter int unsigned IFLG_IDX  = 6,
  parameter int unsigned IPRI_IDX  = 7,
  parameter int unsigned ISTAT_IDX = 8,
  localparam int unsigned VEC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        csr_we,
  input  logic [ADDR_W-1:0]           csr_waddr,
  input  logic [DATA_W-1:0]           csr_wdata,
  input  logic [ADDR_W-1:0]           csr_raddr,
  output logic [DATA_W-1:0]           csr_rdata,
  output logic [NUM_CSR*DATA_W-1:0]   csr_flat_o,
  input  logic [NUM_SRC-1:0]          src_i,
  output logic                        irq_o,
  output logic                        irq_level_o,
  output logic [VEC_W-1:0]            irq_vec_o,
  input  logic                        irq_ack_i,
  input  logic                        iret_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW_ACT,
    ST_HIGH_ACT,
    ST_NEST
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_csr     [NUM_CSR];
  logic [DATA_W-1:0]   w_csr_nxt [NUM_CSR];
  logic [DATA_W-1:0]   w_view    [NUM_CSR];
  logic [NUM_SRC-1:0]  r_src_prev;
  logic [DATA_W-1:0]   w_rise;
  logic [DATA_W-1:0]   w_src_mask;
  logic [NUM_SRC-1:0]  w_act;
  logic [NUM_SRC-1:0]  w_hi_mask;
  logic [NUM_SRC-1:0]  w_lo_mask;
  logic [NUM_SRC-1:0]  w_sel_mask;
  logic                w_pend_hi;
  logic                w_pend_lo;
  logic                w_gie;
  logic                w_irq;
  logic                w_nest;
  logic                w_hi_act;
  logic                w_lo_act;

  always_comb begin
    w_src_mask = '0;
    w_src_mask[NUM_SRC-1:0] = '1;
    w_rise = '0;
    w_rise[NUM_SRC-1:0] = src_i & ~r_src_prev;
  end

  assign w_gie      = r_csr[ISTAT_IDX][0];
  assign w_act      = r_csr[IFLG_IDX][NUM_SRC-1:0] & r_csr[IEN_IDX][NUM_SRC-1:0];
  assign w_hi_mask  = w_act & r_csr[IPRI_IDX][NUM_SRC-1:0];
  assign w_lo_mask  = w_act & ~r_csr[IPRI_IDX][NUM_SRC-1:0];
  assign w_pend_hi  = |w_hi_mask;
  assign w_pend_lo  = |w_lo_mask;
  assign w_sel_mask = w_pend_hi ? w_hi_mask : w_lo_mask;

  assign w_nest   = (r_state == ST_NEST);
  assign w_hi_act = (r_state == ST_HIGH_ACT) | w_nest;
  assign w_lo_act = (r_state == ST_LOW_ACT) | w_nest;

  // Flag set is merged after the W1C clear so a same-cycle rising edge wins.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CSR; i++) begin
      w_csr_nxt[i] = r_csr[i];
      if (csr_we && (csr_waddr == ADDR_W'(i))) begin
        if (i == IFLG_IDX) begin
          w_csr_nxt[i] = r_csr[i] & ~csr_wdata;
        end else if ((i == IEN_IDX) || (i == IPRI_IDX)) begin
          w_csr_nxt[i] = csr_wdata & w_src_mask;
        end else if (i == ISTAT_IDX) begin
          w_csr_nxt[i] = csr_wdata & DATA_W'(1);
        end else begin
          w_csr_nxt[i] = csr_wdata;
        end
      end
      if (i == IFLG_IDX) begin
        w_csr_nxt[i] = w_csr_nxt[i] | w_rise;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csr      <= '{default: '0};
      r_src_prev <= '0;
      r_state    <= ST_IDLE;
    end else begin
      r_csr      <= w_csr_nxt;
      r_src_prev <= src_i;
      r_state    <= w_state_nxt;
    end
  end

  // ISTAT status bits are derived from the FSM rather than stored.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CSR; i++) begin
      w_view[i] = r_csr[i];
      if (i == ISTAT_IDX) begin
        w_view[i][3:1] = {w_nest, w_hi_act, w_lo_act};
      end
    end
  end

  always_comb begin
    csr_rdata  = '0;
    csr_flat_o = '0;
    for (int unsigned i = 0; i < NUM_CSR; i++) begin
      csr_flat_o[i*DATA_W +: DATA_W] = w_view[i];
      if (csr_raddr == ADDR_W'(i)) begin
        csr_rdata = w_view[i];
      end
    end
  end

  assign w_irq = w_gie & ~iret_i &
                 (((r_state == ST_IDLE) & (w_pend_hi | w_pend_lo)) |
                  ((r_state == ST_LOW_ACT) & w_pend_hi));

  assign irq_o       = w_irq;
  assign irq_level_o = w_pend_hi;

  always_comb begin
    irq_vec_o = '0;
    if (w_irq) begin
      for (int unsigned k = NUM_SRC; k > 0; k--) begin
        if (w_sel_mask[k-1]) begin
          irq_vec_o = VEC_W'(k - 1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (iret_i) begin
      case (r_state)
        ST_NEST:     w_state_nxt = ST_LOW_ACT;
        ST_HIGH_ACT: w_state_nxt = ST_IDLE;
        ST_LOW_ACT:  w_state_nxt = ST_IDLE;
        default:     w_state_nxt = r_state;
      endcase
    end else if (w_irq && irq_ack_i) begin
      case (r_state)
        ST_IDLE:    w_state_nxt = w_pend_hi ? ST_HIGH_ACT : ST_LOW_ACT;
        ST_LOW_ACT: w_state_nxt = ST_NEST;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

endmodule
